mem_arbiter: RTL and testbench

- Shares the single four-banked main memory between the instruction-cache and data-cache controllers.
- Grants one requester at a time and holds the grant for that requester's whole miss sequence (write-back plus fill).
- Forwards the owner's rd/wr/addr/data to memory and returns stall/err to the owner only.
- Tags each accepted read so the read data and its valid strobe go back to the requester that issued it, even after ownership changes.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_read_tag_pipe.sv | 29 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache main-memory arbiter.
// Holds state encodings, requester IDs and read-tag layout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int READ_LAT_DEF = 2;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_read_tag_pipe.sv
// Fixed-latency shift register of {valid, owner} read tags.
// The tail lines up with mem_data_out of the tagged read.
module read_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = READ_LAT_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t push,
  output rd_tag_t tail
);

  rd_tag_t pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// I/D-cache arbiter for the shared main memory.
// Optional MEM_ARB_STATS_EN adds grant/contention counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int READ_LAT    = READ_LAT_DEF,
  parameter int DCACHE_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              d_req,
  input  logic              i_rd,
  input  logic              d_rd,
  input  logic              i_wr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [DATA_W-1:0] d_data_in,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              i_stall,
  output logic              d_stall,
  output logic              i_rd_valid,
  output logic              d_rd_valid,
  output logic              i_err,
  output logic              d_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_stall,
  input  logic              mem_err,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       i_grant_cnt,
  output logic [15:0]       d_grant_cnt,
  output logic [15:0]       contend_cnt
`endif
);

  arb_state_e state, state_nxt;
  logic       rr, rr_nxt;
  logic       i_own, d_own;
  logic       own_rd, own_wr;
  logic       illegal;
  rd_tag_t    push, tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr    <= REQ_I;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  // rr names the requester preferred on the next tie
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (DCACHE_PRIO != 0 || rr == REQ_D) begin
            state_nxt = OWN_D;
            rr_nxt    = REQ_I;
          end else begin
            state_nxt = OWN_I;
            rr_nxt    = REQ_D;
          end
        end else if (i_req) begin
          state_nxt = OWN_I;
        end else if (d_req) begin
          state_nxt = OWN_D;
        end
      end
      OWN_I: begin
        if (!i_req) begin
          if (d_req) begin
            state_nxt = OWN_D;
            rr_nxt    = REQ_I;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      OWN_D: begin
        if (!d_req) begin
          if (i_req) begin
            state_nxt = OWN_I;
            rr_nxt    = REQ_D;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign i_own = (state == OWN_I);
  assign d_own = (state == OWN_D);
  assign i_gnt = i_own;
  assign d_gnt = d_own;

  assign own_rd  = (i_own & i_rd) | (d_own & d_rd);
  assign own_wr  = (i_own & i_wr) | (d_own & d_wr);
  assign illegal = own_rd & own_wr;

  assign mem_rd = own_rd & ~own_wr;
  assign mem_wr = own_wr & ~own_rd;

  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    unique case (1'b1)
      i_own: begin
        mem_addr    = i_addr;
        mem_data_in = i_data_in;
      end
      d_own: begin
        mem_addr    = d_addr;
        mem_data_in = d_data_in;
      end
      default: ;
    endcase
  end

  // Waiting requesters stall; masked while reset holds outputs low
  assign i_stall = ~rst & (i_own ? mem_stall : i_req);
  assign d_stall = ~rst & (d_own ? mem_stall : d_req);

  assign i_err = i_own & (mem_err | illegal);
  assign d_err = d_own & (mem_err | illegal);

  assign push.valid = mem_rd & ~mem_stall;
  assign push.owner = d_own ? REQ_D : REQ_I;

  read_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .tail (tail)
  );

  assign i_rd_valid = tail.valid & (tail.owner == REQ_I);
  assign d_rd_valid = tail.valid & (tail.owner == REQ_D);
  assign rd_data    = mem_data_out;

`ifdef MEM_ARB_STATS_EN
  logic contend;

  assign contend = (i_own & d_req) | (d_own & i_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      contend_cnt <= '0;
    end else begin
      if (state_nxt == OWN_I && state != OWN_I)
        i_grant_cnt <= sat_inc(i_grant_cnt);
      if (state_nxt == OWN_D && state != OWN_D)
        d_grant_cnt <= sat_inc(d_grant_cnt);
      if (contend)
        contend_cnt <= sat_inc(contend_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Scenario tasks run in sequence from one initial block.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, i_rd, d_rd, i_wr, d_wr;
  logic [15:0] i_addr, d_addr, i_data_in, d_data_in;
  logic        i_gnt, d_gnt, i_stall, d_stall;
  logic        i_rd_valid, d_rd_valid, i_err, d_err;
  logic [15:0] rd_data;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_data_in;
  logic        mem_stall, mem_err;
  logic [15:0] mem_data_out;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] i_grant_cnt, d_grant_cnt, contend_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .d_req        (d_req),
    .i_rd         (i_rd),
    .d_rd         (d_rd),
    .i_wr         (i_wr),
    .d_wr         (d_wr),
    .i_addr       (i_addr),
    .d_addr       (d_addr),
    .i_data_in    (i_data_in),
    .d_data_in    (d_data_in),
    .i_gnt        (i_gnt),
    .d_gnt        (d_gnt),
    .i_stall      (i_stall),
    .d_stall      (d_stall),
    .i_rd_valid   (i_rd_valid),
    .d_rd_valid   (d_rd_valid),
    .i_err        (i_err),
    .d_err        (d_err),
    .rd_data      (rd_data),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err),
    .mem_data_out (mem_data_out)
`ifdef MEM_ARB_STATS_EN
    ,
    .i_grant_cnt  (i_grant_cnt),
    .d_grant_cnt  (d_grant_cnt),
    .contend_cnt  (contend_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {i_req, d_req, i_rd, d_rd, i_wr, d_wr} = '0;
    {i_addr, d_addr, i_data_in, d_data_in} = '0;
    {mem_stall, mem_err} = '0;
    mem_data_out = '0;
    tick();
    tick();
    vecs++;
    if ({i_gnt, d_gnt, i_stall, d_stall, i_rd_valid, d_rd_valid,
         i_err, d_err, mem_rd, mem_wr} !== 10'b0) begin
      errs++;
      $display("FAIL reset_ctl got %b exp 0", {i_gnt, d_gnt, i_stall,
               d_stall, i_rd_valid, d_rd_valid, i_err, d_err, mem_rd, mem_wr});
    end
    vecs++;
    if ({mem_addr, mem_data_in, rd_data} !== 48'h0) begin
      errs++;
      $display("FAIL reset_data got %h exp 0", {mem_addr, mem_data_in, rd_data});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    i_req = 1'b1; i_rd = 1'b1; i_addr = 16'h0040;
    #1;
    vecs++;
    if (i_gnt !== 1'b0 || mem_rd !== 1'b0) begin
      errs++;
      $display("FAIL single_c0 gnt %b rd %b exp 0 0", i_gnt, mem_rd);
    end
    tick();
    vecs++;
    if (i_gnt !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin
      errs++;
      $display("FAIL single_c1 gnt %b rd %b addr %h exp 1 1 0040",
               i_gnt, mem_rd, mem_addr);
    end
    vecs++;
    if ({d_gnt, d_stall, d_rd_valid, d_err, i_stall} !== 5'b0) begin
      errs++;
      $display("FAIL single_d_quiet got %b exp 0",
               {d_gnt, d_stall, d_rd_valid, d_err, i_stall});
    end
    tick();
    i_rd = 1'b0;
    vecs++;
    if (i_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_early_valid got %b exp 0", i_rd_valid);
    end
    tick();
    vecs++;
    if (i_rd_valid !== 1'b1 || d_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_valid i %b d %b exp 1 0", i_rd_valid, d_rd_valid);
    end
    i_req = 1'b0;
    tick();
    vecs++;
    if (i_gnt !== 1'b0 || i_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_release gnt %b vld %b exp 0 0", i_gnt, i_rd_valid);
    end
  endtask

  task automatic test_tie();
    i_req = 1'b1; i_wr = 1'b1; i_addr = 16'h0010; i_data_in = 16'h1111;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_data_in = 16'h2222;
    #1;
    vecs++;
    if (i_stall !== 1'b1 || d_stall !== 1'b1 || mem_wr !== 1'b0) begin
      errs++;
      $display("FAIL tie_idle istall %b dstall %b wr %b exp 1 1 0",
               i_stall, d_stall, mem_wr);
    end
    tick();
    vecs++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || d_stall !== 1'b1 || i_stall !== 1'b0) begin
      errs++;
      $display("FAIL tie_grant ig %b dg %b ds %b is %b exp 1 0 1 0",
               i_gnt, d_gnt, d_stall, i_stall);
    end
    vecs++;
    if (mem_wr !== 1'b1 || mem_addr !== 16'h0010 || mem_data_in !== 16'h1111) begin
      errs++;
      $display("FAIL tie_i_cmd wr %b addr %h data %h exp 1 0010 1111",
               mem_wr, mem_addr, mem_data_in);
    end
    tick();
    vecs++;
    if (d_stall !== 1'b1 || i_gnt !== 1'b1) begin
      errs++;
      $display("FAIL tie_hold ds %b ig %b exp 1 1", d_stall, i_gnt);
    end
    i_req = 1'b0; i_wr = 1'b0;
    tick();
    vecs++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || d_stall !== 1'b0) begin
      errs++;
      $display("FAIL tie_handoff dg %b ig %b ds %b exp 1 0 0",
               d_gnt, i_gnt, d_stall);
    end
    vecs++;
    if (mem_wr !== 1'b1 || mem_addr !== 16'h0020 || mem_data_in !== 16'h2222) begin
      errs++;
      $display("FAIL tie_d_cmd wr %b addr %h data %h exp 1 0020 2222",
               mem_wr, mem_addr, mem_data_in);
    end
    d_req = 1'b0; d_wr = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    i_req = 1'b1; d_req = 1'b1;
    tick();
    vecs++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errs++;
      $display("FAIL rr_first ig %b dg %b exp 1 0", i_gnt, d_gnt);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    i_req = 1'b1; d_req = 1'b1;
    tick();
    vecs++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
      errs++;
      $display("FAIL rr_second ig %b dg %b exp 0 1", i_gnt, d_gnt);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_owner_change();
    d_req = 1'b1;
    tick();
    d_rd = 1'b1; d_addr = 16'h0080; i_req = 1'b1;
    #1;
    vecs++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0080 || i_stall !== 1'b1) begin
      errs++;
      $display("FAIL chg_issue rd %b addr %h is %b exp 1 0080 1",
               mem_rd, mem_addr, i_stall);
    end
    tick();
    d_req = 1'b0; d_rd = 1'b0;
    vecs++;
    if (d_rd_valid !== 1'b0 || d_gnt !== 1'b1) begin
      errs++;
      $display("FAIL chg_mid vld %b dg %b exp 0 1", d_rd_valid, d_gnt);
    end
    tick();
    mem_data_out = 16'hBEEF;
    #1;
    vecs++;
    if (i_gnt !== 1'b1 || d_rd_valid !== 1'b1 || i_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL chg_valid ig %b dv %b iv %b exp 1 1 0",
               i_gnt, d_rd_valid, i_rd_valid);
    end
    vecs++;
    if (rd_data !== 16'hBEEF) begin
      errs++;
      $display("FAIL chg_rd_data got %h exp beef", rd_data);
    end
    tick();
    vecs++;
    if (d_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL chg_single_pulse got %b exp 0", d_rd_valid);
    end
    i_req = 1'b0;
    mem_data_out = '0;
    tick();
  endtask

  task automatic test_stall();
    i_req = 1'b1; i_wr = 1'b1; i_addr = 16'h0100; i_data_in = 16'hABCD;
    tick();
    mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++;
      if (i_stall !== 1'b1 || mem_wr !== 1'b1 || i_rd_valid !== 1'b0) begin
        errs++;
        $display("FAIL stall_wr_%0d is %b wr %b iv %b exp 1 1 0",
                 k, i_stall, mem_wr, i_rd_valid);
      end
      tick();
    end
    mem_stall = 1'b0;
    #1;
    vecs++;
    if (i_stall !== 1'b0 || mem_wr !== 1'b1 || mem_data_in !== 16'hABCD) begin
      errs++;
      $display("FAIL stall_wr_done is %b wr %b data %h exp 0 1 abcd",
               i_stall, mem_wr, mem_data_in);
    end
    tick();
    i_wr = 1'b0; i_rd = 1'b1; mem_stall = 1'b1;
    tick();
    mem_stall = 1'b0;
    tick();
    i_rd = 1'b0;
    vecs++;
    if (i_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_rd_early got %b exp 0", i_rd_valid);
    end
    tick();
    vecs++;
    if (i_rd_valid !== 1'b1) begin
      errs++;
      $display("FAIL stall_rd_valid got %b exp 1", i_rd_valid);
    end
    tick();
  endtask

  task automatic test_illegal();
    i_rd = 1'b1; i_wr = 1'b1;
    #1;
    vecs++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || i_err !== 1'b1 || d_err !== 1'b0) begin
      errs++;
      $display("FAIL illegal rd %b wr %b ie %b de %b exp 0 0 1 0",
               mem_rd, mem_wr, i_err, d_err);
    end
    i_rd = 1'b0; i_wr = 1'b0; mem_err = 1'b1; d_req = 1'b1;
    #1;
    vecs++;
    if (i_err !== 1'b1 || d_err !== 1'b0) begin
      errs++;
      $display("FAIL mem_err_route ie %b de %b exp 1 0", i_err, d_err);
    end
    mem_err = 1'b0; d_req = 1'b0;
    #1;
    vecs++;
    if (i_err !== 1'b0) begin
      errs++;
      $display("FAIL err_clear got %b exp 0", i_err);
    end
  endtask

  task automatic test_reset_mid();
    i_rd = 1'b1; i_addr = 16'h0200;
    tick();
    rst = 1'b1;
    #1;
    vecs++;
    if ({i_gnt, i_stall, mem_rd, i_rd_valid, i_err} !== 5'b0) begin
      errs++;
      $display("FAIL rst_mid got %b exp 0",
               {i_gnt, i_stall, mem_rd, i_rd_valid, i_err});
    end
    tick();
    rst = 1'b0; i_rd = 1'b0;
    #1;
    vecs++;
    if (i_gnt !== 1'b0 || i_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_idle ig %b iv %b exp 0 0", i_gnt, i_rd_valid);
    end
    tick();
    vecs++;
    if (i_gnt !== 1'b1 || i_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_regrant ig %b iv %b exp 1 0", i_gnt, i_rd_valid);
    end
    tick();
    vecs++;
    if (i_rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_no_stale got %b exp 0", i_rd_valid);
    end
    i_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_owner_change();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
